// File: rtl/riscv_pkg.sv
// -----------------------------------------------------------------------------
// riscv_pkg
// Shared types and constants for the multicycle RISC-V control path:
//   - state_t     : control FSM states
//   - OP_*        : supported major opcodes
//   - alu_op_t    : main-FSM to ALU-decoder operation class
//   - ALU_*       : alu_control encodings driven to the datapath ALU
//   - op_supported: true for every opcode the FSM can execute
// -----------------------------------------------------------------------------
package riscv_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECUTER,
    S_EXECUTEI,
    S_ALUWB,
    S_BEQ,
    S_JAL
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } alu_op_t;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  function automatic logic op_supported(input logic [6:0] op);
    return (op == OP_LOAD)  || (op == OP_STORE)  || (op == OP_RTYPE) ||
           (op == OP_ITYPE) || (op == OP_BRANCH) || (op == OP_JAL);
  endfunction

endpackage

// File: rtl/riscv_alu_decoder.sv
// -----------------------------------------------------------------------------
// riscv_alu_decoder
// Turns the FSM's ALU operation class plus instruction fields into the ALU
// control code.
//   alu_op      : operation class from the control FSM
//   funct3      : instruction bits 14:12
//   op_5        : opcode bit 5 (1 = R-type, 0 = I-type for the ALU group)
//   funct7      : instruction bit 30
//   alu_control : ALU function select
// -----------------------------------------------------------------------------
module riscv_alu_decoder
  import riscv_pkg::*;
(
  input  alu_op_t    alu_op,
  input  logic [2:0] funct3,
  input  logic       op_5,
  input  logic       funct7,
  output logic [2:0] alu_control
);

  always_comb begin
    // NOTE: default first so every path assigns alu_control and no latch is inferred.
    alu_control = ALU_ADD;
    case (alu_op)
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          // Only R-type sub sets bit 30; addi uses that bit as immediate data.
          3'b000:  alu_control = (op_5 && funct7) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control = ALU_SLT;
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          default: alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/riscv_mc_control.sv
// -----------------------------------------------------------------------------
// riscv_mc_control
// Control unit of a multicycle RISC-V core (lw, sw, R-type, I-type ALU, beq,
// jal). A Moore FSM sequences the datapath; control outputs are decoded from
// the registered state.
//   clk, rst_n     : clock, synchronous active-low reset
//   op, funct3,    : instruction fields from the instruction register
//   funct7
//   zero           : ALU zero flag (branch resolution)
//   mem_ready      : memory access completes this cycle
//   pc_write, adr_src, mem_write, ir_write, reg_write, result_src,
//   alu_src_a, alu_src_b, imm_src, alu_control : datapath controls
//   instr_done     : pulse in the last cycle of a retiring instruction
//   illegal_op     : pulse in DECODE when the opcode is unsupported
// Build option: define RISCV_MC_MEM_WAIT_EN to make FETCH, MEMREAD and
// MEMWRITE wait for mem_ready; otherwise mem_ready is ignored.
// -----------------------------------------------------------------------------
module riscv_mc_control
  import riscv_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] imm_src,
  output logic [2:0] alu_control,
  output logic       instr_done,
  output logic       illegal_op
);

  state_t  state_q, state_d;
  alu_op_t alu_op;
  logic    mem_ok;
  logic    pc_update, branch;
  logic    ir_write_s, mem_write_s, reg_write_s, done_s, illegal_s;

`ifdef RISCV_MC_MEM_WAIT_EN
  assign mem_ok = mem_ready;
`else
  logic unused_mem_ready;
  assign unused_mem_ready = mem_ready;
  assign mem_ok = 1'b1;
`endif

  // Next-state logic; memory states stall until mem_ok.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:    if (mem_ok) state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXECUTER;
          OP_ITYPE:          state_d = S_EXECUTEI;
          OP_BRANCH:         state_d = S_BEQ;
          OP_JAL:            state_d = S_JAL;
          default:           state_d = S_FETCH;
        endcase
      end
      S_MEMADR:   state_d = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  if (mem_ok) state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: if (mem_ok) state_d = S_FETCH;
      S_EXECUTER: state_d = S_ALUWB;
      S_EXECUTEI: state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BEQ:      state_d = S_FETCH;
      S_JAL:      state_d = S_ALUWB;
      default:    state_d = S_FETCH;
    endcase
  end

  // Moore output decode from the registered state. FETCH's strobes are
  // qualified by mem_ok so a stalled fetch neither loads IR nor bumps PC.
  always_comb begin
    adr_src     = 1'b0;
    ir_write_s  = 1'b0;
    mem_write_s = 1'b0;
    reg_write_s = 1'b0;
    pc_update   = 1'b0;
    branch      = 1'b0;
    alu_src_a   = 2'b00;
    alu_src_b   = 2'b00;
    alu_op      = ALUOP_ADD;
    result_src  = 2'b00;
    case (state_q)
      S_FETCH: begin
        ir_write_s = mem_ok;
        pc_update  = mem_ok;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
      end
      S_MEMREAD:  adr_src = 1'b1;
      S_MEMWB: begin
        result_src  = 2'b01;
        reg_write_s = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src     = 1'b1;
        mem_write_s = 1'b1;
      end
      S_EXECUTER: begin
        alu_src_a = 2'b10;
        alu_op    = ALUOP_FUNCT;
      end
      S_EXECUTEI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB:    reg_write_s = 1'b1;
      S_BEQ: begin
        alu_src_a = 2'b10;
        alu_op    = ALUOP_SUB;
        branch    = 1'b1;
      end
      S_JAL: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_update = 1'b1;
      end
      default: ;
    endcase
  end

  // Retirement: a terminal state that is actually leaving for FETCH
  // (MEMWRITE may be stalled on memory).
  always_comb begin
    done_s    = (state_d == S_FETCH) &&
                ((state_q == S_MEMWB) || (state_q == S_MEMWRITE) ||
                 (state_q == S_ALUWB) || (state_q == S_BEQ));
    illegal_s = (state_q == S_DECODE) && !op_supported(op);
  end

  always_comb begin
    case (op)
      OP_STORE:  imm_src = 2'b01;
      OP_BRANCH: imm_src = 2'b10;
      OP_JAL:    imm_src = 2'b11;
      default:   imm_src = 2'b00;
    endcase
  end

  // State-changing strobes are held off while reset is asserted.
  assign pc_write   = rst_n & (pc_update | (branch & zero));
  assign ir_write   = rst_n & ir_write_s;
  assign reg_write  = rst_n & reg_write_s;
  assign mem_write  = rst_n & mem_write_s;
  assign instr_done = rst_n & done_s;
  assign illegal_op = rst_n & illegal_s;

  riscv_alu_decoder u_alu_decoder (
    .alu_op      (alu_op),
    .funct3      (funct3),
    .op_5        (op[5]),
    .funct7      (funct7),
    .alu_control (alu_control)
  );

  // NOTE: sequential state uses non-blocking assignment so every flop samples
  // pre-edge values; the synchronous reset is simply the first branch.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

endmodule

// File: tb/tb_riscv_mc_control.sv
// -----------------------------------------------------------------------------
// tb_riscv_mc_control
// Self-checking bench for riscv_mc_control. A reference model derives the
// state path of each instruction class and the per-state control table,
// then compares every output each cycle. Build with RISCV_MC_MEM_WAIT_EN to
// exercise the memory wait states.
// -----------------------------------------------------------------------------
module tb_riscv_mc_control;
  import riscv_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7, zero, mem_ready;
  logic       pc_write, adr_src, mem_write, ir_write, reg_write;
  logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
  logic [2:0] alu_control;
  logic       instr_done, illegal_op;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  riscv_mc_control dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7(funct7),
    .zero(zero), .mem_ready(mem_ready), .pc_write(pc_write),
    .adr_src(adr_src), .mem_write(mem_write), .ir_write(ir_write),
    .reg_write(reg_write), .result_src(result_src), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .imm_src(imm_src), .alu_control(alu_control),
    .instr_done(instr_done), .illegal_op(illegal_op)
  );

  // Per-state control row: adr_src, ir_write, mem_write, reg_write,
  // pc_update, branch, then a, b, alu_op, result_src.
  typedef struct packed {
    logic [5:0] flags;
    logic [1:0] a, b, aop, res;
  } row_t;
  row_t tbl [11];

  initial begin
    tbl[int'(S_FETCH)]    = {6'b010010, 2'b00, 2'b10, 2'b00, 2'b10};
    tbl[int'(S_DECODE)]   = {6'b000000, 2'b01, 2'b01, 2'b00, 2'b00};
    tbl[int'(S_MEMADR)]   = {6'b000000, 2'b10, 2'b01, 2'b00, 2'b00};
    tbl[int'(S_MEMREAD)]  = {6'b100000, 2'b00, 2'b00, 2'b00, 2'b00};
    tbl[int'(S_MEMWB)]    = {6'b000100, 2'b00, 2'b00, 2'b00, 2'b01};
    tbl[int'(S_MEMWRITE)] = {6'b101000, 2'b00, 2'b00, 2'b00, 2'b00};
    tbl[int'(S_EXECUTER)] = {6'b000000, 2'b10, 2'b00, 2'b10, 2'b00};
    tbl[int'(S_EXECUTEI)] = {6'b000000, 2'b10, 2'b01, 2'b10, 2'b00};
    tbl[int'(S_ALUWB)]    = {6'b000100, 2'b00, 2'b00, 2'b00, 2'b00};
    tbl[int'(S_BEQ)]      = {6'b000001, 2'b10, 2'b00, 2'b01, 2'b00};
    tbl[int'(S_JAL)]      = {6'b000010, 2'b01, 2'b10, 2'b00, 2'b00};
  end

  function automatic bit legal(input logic [6:0] o);
    return o inside {7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                     7'b1100011, 7'b1101111};
  endfunction

  function automatic logic [1:0] ref_imm(input logic [6:0] o);
    if (o == 7'b0100011) return 2'b01;
    if (o == 7'b1100011) return 2'b10;
    if (o == 7'b1101111) return 2'b11;
    return 2'b00;
  endfunction

  function automatic logic [2:0] ref_alu(input logic [1:0] aop, input logic [6:0] o,
                                         input logic [2:0] f3, input logic f7);
    if (aop == 2'b00) return 3'b000;
    if (aop == 2'b01) return 3'b001;
    if (aop != 2'b10) return 3'b000;
    if (f3 == 3'b000) return (o[5] && f7) ? 3'b001 : 3'b000;
    if (f3 == 3'b010) return 3'b101;
    if (f3 == 3'b110) return 3'b011;
    if (f3 == 3'b111) return 3'b010;
    return 3'b000;
  endfunction

  // Ordered list of states an instruction visits with no wait states.
  function automatic void ref_path(input logic [6:0] o, output state_t p[$]);
    p = '{S_FETCH, S_DECODE};
    case (o)
      7'b0000011: p = {p, S_MEMADR, S_MEMREAD, S_MEMWB};
      7'b0100011: p = {p, S_MEMADR, S_MEMWRITE};
      7'b0110011: p = {p, S_EXECUTER, S_ALUWB};
      7'b0010011: p = {p, S_EXECUTEI, S_ALUWB};
      7'b1100011: p = {p, S_BEQ};
      7'b1101111: p = {p, S_JAL, S_ALUWB};
      default: ;
    endcase
  endfunction

  function automatic logic [17:0] observed();
    return {pc_write, adr_src, mem_write, ir_write, reg_write, result_src,
            alu_src_a, alu_src_b, imm_src, alu_control, instr_done, illegal_op};
  endfunction

  function automatic logic [17:0] expected(input state_t s, input bit last,
                                           input logic [6:0] o, input logic [2:0] f3,
                                           input logic f7, input logic z);
    row_t r;
    logic pcw;
    r   = tbl[int'(s)];
    pcw = r.flags[1] | (r.flags[0] & z);
    return {pcw, r.flags[5], r.flags[3], r.flags[4], r.flags[2], r.res,
            r.a, r.b, ref_imm(o), ref_alu(r.aop, o, f3, f7),
            last && legal(o), (s == S_DECODE) && !legal(o)};
  endfunction

  // Runs one instruction from FETCH and checks state and all outputs in
  // every cycle, then checks that the next instruction starts at FETCH.
  task automatic run_instr(input string name, input logic [6:0] o, input logic [2:0] f3,
                           input logic f7, input logic z, input logic mr);
    state_t p[$];
    logic [17:0] exp_v;
    ref_path(o, p);
    op = o; funct3 = f3; funct7 = f7; zero = z; mem_ready = mr;
    for (int i = 0; i < p.size(); i++) begin
      @(negedge clk);
      exp_v = expected(p[i], i == p.size() - 1, o, f3, f7, z);
      checks++;
      if (dut.state_q !== p[i]) begin
        errors++;
        $display("FAIL %s state c%0d: got %s want %s", name, i, dut.state_q.name(), p[i].name());
      end
      checks++;
      if (observed() !== exp_v) begin
        errors++;
        $display("FAIL %s outputs c%0d (%s): got %h want %h", name, i, p[i].name(), observed(), exp_v);
      end
      @(posedge clk); #1;
    end
    @(negedge clk);
    checks++;
    if (dut.state_q !== S_FETCH) begin
      errors++;
      $display("FAIL %s length: got state %s after %0d cycles want FETCH", name, dut.state_q.name(), p.size());
    end
    @(posedge clk); #1;
    // The FETCH just checked was the next instruction's first cycle; rewind
    // by holding in reset for one edge so the next call starts at FETCH.
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; op = 7'b0110011; funct3 = 3'b000; funct7 = 1'b0;
    zero = 1'b1; mem_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (dut.state_q !== S_FETCH) begin
      errors++;
      $display("FAIL reset_state: got %s want FETCH", dut.state_q.name());
    end
    checks++;
    if ({pc_write, ir_write, reg_write, mem_write, instr_done, illegal_op} !== 6'b0) begin
      errors++;
      $display("FAIL reset_strobes: got %b want 000000",
               {pc_write, ir_write, reg_write, mem_write, instr_done, illegal_op});
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_rtype();
    run_instr("add", 7'b0110011, 3'b000, 1'b0, 1'b0, 1'b1);
    run_instr("sub", 7'b0110011, 3'b000, 1'b1, 1'b0, 1'b1);
    run_instr("or",  7'b0110011, 3'b110, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_itype();
    run_instr("addi_f7", 7'b0010011, 3'b000, 1'b1, 1'b0, 1'b1);
    run_instr("slti",    7'b0010011, 3'b010, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic test_beq();
    run_instr("beq_taken",  7'b1100011, 3'b000, 1'b0, 1'b1, 1'b1);
    run_instr("beq_not",    7'b1100011, 3'b000, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_load_store();
    run_instr("lw",  7'b0000011, 3'b010, 1'b0, 1'b0, 1'b1);
    run_instr("sw",  7'b0100011, 3'b010, 1'b0, 1'b0, 1'b1);
    run_instr("jal", 7'b1101111, 3'b000, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic test_illegal();
    run_instr("illegal0", 7'b0000000, 3'b000, 1'b0, 1'b0, 1'b1);
    run_instr("illegal1", 7'b1110011, 3'b001, 1'b1, 1'b1, 1'b1);
  endtask

  task automatic test_reset_mid();
    op = 7'b0000011; funct3 = 3'b010; funct7 = 1'b0; zero = 1'b0; mem_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (dut.state_q !== S_MEMADR) begin
      errors++;
      $display("FAIL reset_mid_pre: got %s want MEMADR", dut.state_q.name());
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (dut.state_q !== S_FETCH) begin
      errors++;
      $display("FAIL reset_mid: got %s want FETCH", dut.state_q.name());
    end
    checks++;
    if (ir_write !== 1'b1 || pc_write !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_fetch: got ir=%b pc=%b want 1 1", ir_write, pc_write);
    end
    // Hold reset across one edge so the next test starts at FETCH.
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

`ifdef RISCV_MC_MEM_WAIT_EN
  task automatic test_mem_wait();
    int mw_cycles = 0;
    int done_cycles = 0;
    op = 7'b0100011; funct3 = 3'b010; funct7 = 1'b0; zero = 1'b0;
    for (int i = 0; i < 7; i++) begin
      mem_ready = (i >= 3 && i <= 5) ? 1'b0 : 1'b1;
      @(negedge clk);
      if (mem_write === 1'b1) mw_cycles++;
      if (instr_done === 1'b1) done_cycles++;
      @(posedge clk); #1;
    end
    mem_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (mw_cycles != 4) begin
      errors++;
      $display("FAIL mem_wait_mw: got %0d cycles want 4", mw_cycles);
    end
    checks++;
    if (done_cycles != 1) begin
      errors++;
      $display("FAIL mem_wait_done: got %0d pulses want 1", done_cycles);
    end
    checks++;
    if (dut.state_q !== S_FETCH) begin
      errors++;
      $display("FAIL mem_wait_end: got %s want FETCH", dut.state_q.name());
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask
`else
  task automatic test_mem_ready_ignored();
    run_instr("lw_noready", 7'b0000011, 3'b010, 1'b0, 1'b0, 1'b0);
    run_instr("sw_noready", 7'b0100011, 3'b010, 1'b0, 1'b0, 1'b0);
  endtask
`endif

  task automatic test_random();
    logic [6:0] ops [6];
    logic [6:0] o;
    ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011, 7'b1101111};
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 7) == 0) o = 7'($urandom);
      else                           o = ops[$urandom_range(0, 5)];
      run_instr("random", o, 3'($urandom), 1'($urandom), 1'($urandom), 1'b1);
    end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_itype();
    test_beq();
    test_load_store();
    test_illegal();
    test_reset_mid();
`ifdef RISCV_MC_MEM_WAIT_EN
    test_mem_wait();
`else
    test_mem_ready_ignored();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/riscv_mc_control.md
RISCV_MC_CONTROL -- requirements
Module: riscv_mc_control

Interface
REQ-001 SHALL have port: clk  input  1  single rising-edge clock.
REQ-002 SHALL have port: rst_n  input  1  reset, synchronous, active-low.
REQ-003 SHALL have port: op  input  7  opcode from the instruction register.
REQ-004 SHALL have port: funct3  input  3  instruction bits 14:12.
REQ-005 SHALL have port: funct7  input  1  instruction bit 30.
REQ-006 SHALL have port: zero  input  1  ALU zero flag.
REQ-007 SHALL have port: mem_ready  input  1  memory access completes this cycle.
REQ-008 SHALL have outputs, 1 bit each: pc_write, adr_src, mem_write, ir_write and reg_write.
REQ-009 SHALL have outputs: result_src[1:0], alu_src_a[1:0], alu_src_b[1:0], imm_src[1:0] and alu_control[2:0].
REQ-010 SHALL have outputs: instr_done  1  one-cycle pulse when an instruction retires; illegal_op  1  one-cycle pulse when the opcode is unsupported.

Function
REQ-011 SHALL implement a Moore FSM with 11 states: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BEQ and JAL.
REQ-012 FETCH SHALL drive adr_src=0, ir_write=1, a=00, b=10, alu_op=00, result_src=10 and pc_update=1, then go to DECODE.
REQ-013 DECODE SHALL drive a=01, b=01 and alu_op=00, then go to the next state by op:
- 0000011 or 0100011 -> MEMADR
- 0110011 -> EXECUTER
- 0010011 -> EXECUTEI
- 1100011 -> BEQ
- 1101111 -> JAL
- any other op -> FETCH, with illegal_op=1 for that cycle.
REQ-014 MEMADR SHALL drive a=10, b=01 and alu_op=00, then go to MEMREAD if op=0000011, else to MEMWRITE.
REQ-015 MEMREAD SHALL drive adr_src=1 and result_src=00, then go to MEMWB.
REQ-016 MEMWB SHALL drive result_src=01 and reg_write=1, then go to FETCH.
REQ-017 MEMWRITE SHALL drive adr_src=1, result_src=00 and mem_write=1, then go to FETCH.
REQ-018 EXECUTER SHALL drive a=10, b=00 and alu_op=10, then go to ALUWB.
REQ-019 EXECUTEI SHALL drive a=10, b=01 and alu_op=10, then go to ALUWB.
REQ-020 ALUWB SHALL drive result_src=00 and reg_write=1, then go to FETCH.
REQ-021 BEQ SHALL drive a=10, b=00, alu_op=01, result_src=00 and branch=1, then go to FETCH.
REQ-022 JAL SHALL drive a=01, b=10, alu_op=00, result_src=00 and pc_update=1, then go to ALUWB.
REQ-023 Any output not listed for a state SHALL be 0.
REQ-024 pc_write SHALL equal pc_update OR (branch AND zero), combinationally.
REQ-025 imm_src SHALL be decoded from op in every state: 0000011/0010011 -> 00, 0100011 -> 01, 1100011 -> 10, 1101111 -> 11, any other op -> 00.
REQ-026 alu_control SHALL be decoded as follows:
- alu_op=00 -> 000 (add)
- alu_op=01 -> 001 (sub)
- alu_op=10, funct3=000 -> 001 if op[5] AND funct7, else 000
- alu_op=10, funct3=010 -> 101; 110 -> 011; 111 -> 010; any other funct3 -> 000.
REQ-027 instr_done SHALL be 1 in exactly the cycles where the next state is FETCH and the current state is MEMWB, MEMWRITE, ALUWB or BEQ.
REQ-028 A full instruction SHALL take these cycle counts with no wait states: lw 5, sw 4, R-type 4, I-type 4, beq 3, jal 4.

Reset
REQ-029 When rst_n=0 is sampled on a clk edge, the state SHALL become FETCH, including mid-instruction; the partial instruction is abandoned.
REQ-030 While rst_n=0, pc_write, ir_write, reg_write, mem_write, instr_done and illegal_op SHALL be forced to 0 combinationally.
REQ-031 The first cycle after reset is released SHALL be FETCH.

Configuration
REQ-032 If RISCV_MC_MEM_WAIT_EN is defined, FETCH, MEMREAD and MEMWRITE SHALL hold their state until mem_ready=1.
- In FETCH, ir_write and pc_update SHALL assert only in the cycle where mem_ready=1.
- In MEMWRITE, mem_write SHALL stay asserted throughout the wait.
REQ-033 If RISCV_MC_MEM_WAIT_EN is undefined, mem_ready SHALL be ignored and every state SHALL last exactly one cycle.

Structure
REQ-034 Package riscv_pkg SHALL hold:
- the state enum
- opcode constants (OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_BRANCH, OP_JAL)
- alu_op and alu_control encodings.
REQ-035 The ALU decoder SHALL be the sub-module riscv_alu_decoder; all other logic SHALL be in riscv_mc_control.

Verification
REQ-036 Bench SHALL cover: reset, then R-type add (op=0110011, funct3=000, funct7=0) -> states F,D,ER,AW; reg_write=1 in cycle 4; alu_control=000 in ER; instr_done=1 in cycle 4.
REQ-037 Bench SHALL cover: R-type sub (funct7=1) -> alu_control=001; I-type addi with funct7-position bit=1 -> alu_control=000.
REQ-038 Bench SHALL cover: beq with zero=1 -> pc_write=1 in BEQ; beq with zero=0 -> pc_write=0; each takes 3 cycles.
REQ-039 Bench SHALL cover: lw -> 5 cycles, mem_write never 1, result_src=01 in MEMWB; sw -> mem_write=1 exactly once, imm_src=01.
REQ-040 Bench SHALL cover: op=0000000 -> illegal_op=1 in DECODE, next state FETCH, instr_done stays 0.
REQ-041 Bench SHALL cover, with RISCV_MC_MEM_WAIT_EN defined: mem_ready=0 for 3 cycles during MEMWRITE -> mem_write=1 for 4 cycles. Also: rst_n=0 during MEMADR -> state FETCH next cycle.
